// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, default depth and byte-merge helper for the dmem responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } dmem_state_t;

  localparam int DEFAULT_DEPTH = 64;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage with byte-enable write and registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  output logic [31:0]   o_rdata
);

  // Storage is deliberately not reset; only the read register is observable.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= byte_merge(r_mem[i_addr], i_wdata, i_wstrb);
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder: request latch, wait states, access, held response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t r_state, w_next_state;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_load_ok;
  logic        r_err;
  logic        w_access_err;
  logic        w_arr_we;
  logic        w_arr_re;
  logic [31:0] w_arr_rdata;

  // Full-width range check so high address bits can never alias into the array.
  assign w_access_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
  assign w_arr_we     = (r_state == ACCESS) && r_we && !w_access_err;
  assign w_arr_re     = (r_state == ACCESS) && !r_we && !w_access_err;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid && req_ready) begin
          w_cnt_next   = CNT_INIT;
          w_next_state = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next_state = ACCESS;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      ACCESS:  w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_load_ok <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (r_state == ACCESS) begin
        r_err     <= w_access_err;
        r_load_ok <= !r_we && !w_access_err;
      end else if (r_state == RESP && rsp_ready) begin
        r_err     <= 1'b0;
        r_load_ok <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .o_rdata (w_arr_rdata)
  );

  // Array read register holds its value through RESP; gating forces zero outside a good load.
  assign req_ready = reset && (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_load_ok ? w_arr_rdata : 32'd0;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_dmem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    a_req_we    = v.we;
    a_req_addr  = v.addr;
    a_req_wdata = v.wdata;
    a_req_wstrb = v.wstrb;
    a_req_valid = 1'b1;
  endtask

  task automatic accept(input string name);
    int t = 0;
    while (!a_req_ready && t < 20) begin @(posedge clk); #1; t++; end
    check({name, "_ready"}, a_req_ready, 1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int exp_lat);
    int lat = 0;
    while (!a_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic take_rsp(input string name, input logic [31:0] exp_rdata, input logic exp_err);
    check({name, "_rdata"}, a_rsp_rdata, exp_rdata);
    check({name, "_err"}, a_rsp_err, exp_err);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check({name, "_valid_cleared"}, a_rsp_valid, 0);
    check({name, "_err_cleared"}, a_rsp_err, 0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    set_req(v);
    accept(name);
    wait_rsp(name, 3);
    take_rsp(name, v.exp_rdata, v.exp_err);
  endtask

  vec_t vecs [16];
  vec_t bvecs [6];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'd100,        32'h00000019, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd100,        32'h0,        4'h0, 32'h00000019, 1'b0};
    vecs[2]  = '{1'b1, 32'd96,         32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'd96,         32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'd96,         32'h0,        4'hF, 32'hAA22CC44, 1'b0};
    vecs[5]  = '{1'b0, 32'd102,        32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'd256,        32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'd256,        32'h55555555, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h10000060,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'd97,         32'h77777777, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'd96,         32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vecs[11] = '{1'b1, 32'd96,         32'h0,        4'h0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'd96,         32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vecs[13] = '{1'b1, 32'd8,          32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'd252,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'd252,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0};

    bvecs[0] = '{1'b1, 32'd0, 32'h01010101, 4'hF, 32'h0,        1'b0};
    bvecs[1] = '{1'b1, 32'd4, 32'h02020202, 4'hF, 32'h0,        1'b0};
    bvecs[2] = '{1'b1, 32'd8, 32'h03030303, 4'hF, 32'h0,        1'b0};
    bvecs[3] = '{1'b0, 32'd0, 32'h0,        4'h0, 32'h01010101, 1'b0};
    bvecs[4] = '{1'b0, 32'd4, 32'h0,        4'h0, 32'h02020202, 1'b0};
    bvecs[5] = '{1'b0, 32'd8, 32'h0,        4'h0, 32'h03030303, 1'b0};

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wstrb = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0; b_rsp_ready = 1;
    rst_n = 1'b0;

    #2;
    check("reset_req_ready", a_req_ready, 0);
    check("reset_rsp_valid", a_rsp_valid, 0);
    check("reset_rsp_rdata", a_rsp_rdata, 0);
    check("reset_rsp_err", a_rsp_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("release_req_ready", a_req_ready, 1);

    for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Response held under back-pressure while a new request waits.
    v = '{1'b0, 32'd100, 32'h0, 4'h0, 32'h00000019, 1'b0};
    set_req(v);
    accept("t4_first");
    wait_rsp("t4_first", 3);
    a_req_we = 1'b0; a_req_addr = 32'd96; a_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold%0d_valid", k), a_rsp_valid, 1);
      check($sformatf("t4_hold%0d_rdata", k), a_rsp_rdata, 32'h00000019);
      check($sformatf("t4_hold%0d_req_ready", k), a_req_ready, 0);
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("t4_idle_req_ready", a_req_ready, 1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    wait_rsp("t4_second", 3);
    take_rsp("t4_second", 32'hAA22CC44, 1'b0);

    // Reset during WAIT drops an uncommitted store.
    v = '{1'b1, 32'd8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    set_req(v);
    accept("t5_store");
    rst_n = 1'b0;
    #1;
    check("t5_req_ready", a_req_ready, 0);
    check("t5_rsp_valid", a_rsp_valid, 0);
    check("t5_rsp_rdata", a_rsp_rdata, 0);
    check("t5_rsp_err", a_rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("t5_release_req_ready", a_req_ready, 1);
    v = '{1'b0, 32'd8, 32'h0, 4'h0, 32'h12345678, 1'b0};
    run_vec("t5_load", v);

    // Reset during RESP clears a pending error response.
    v = '{1'b0, 32'd102, 32'h0, 4'h0, 32'h0, 1'b1};
    set_req(v);
    accept("tr_err");
    wait_rsp("tr_err", 3);
    check("tr_err_set", a_rsp_err, 1);
    rst_n = 1'b0;
    #1;
    check("tr_err_cleared", a_rsp_err, 0);
    check("tr_valid_cleared", a_rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // Zero-wait instance, rsp_ready tied high: one response every 3 cycles.
    begin
      int prev = 0;
      for (int i = 0; i < 6; i++) begin
        int t = 0;
        b_req_we = bvecs[i].we; b_req_addr = bvecs[i].addr;
        b_req_wdata = bvecs[i].wdata; b_req_wstrb = bvecs[i].wstrb;
        b_req_valid = 1'b1;
        while (!b_req_ready && t < 10) begin @(posedge clk); #1; t++; end
        check($sformatf("t6_%0d_ready", i), b_req_ready, 1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        check($sformatf("t6_%0d_valid", i), b_rsp_valid, 1);
        check($sformatf("t6_%0d_rdata", i), b_rsp_rdata, bvecs[i].exp_rdata);
        check($sformatf("t6_%0d_err", i), b_rsp_err, 0);
        if (i > 0) check($sformatf("t6_%0d_spacing", i), cyc - prev, 3);
        prev = cyc;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
